// File: rtl/sigmoid_pkg.sv
// Shared constants, FSM state type and segment-base helper for the sigmoid evaluator.
package sigmoid_pkg;

    localparam int unsigned DWIDTH = 32;
    localparam int unsigned FRAC   = 24;

    localparam logic [DWIDTH-1:0] ONE     = 32'h0100_0000;
    localparam logic [2:0]        SEG_SAT = 3'd6;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMac1,
        StMac2,
        StFix,
        StDone
    } state_e;

    // Segments 4 and 5 share one expansion point at 4.0.
    function automatic logic [2:0] seg_base(input logic [2:0] seg);
        seg_base = (seg == 3'd4 || seg == 3'd5) ? 3'd4 : seg;
    endfunction

endpackage

// File: rtl/q824_mul.sv
// Signed Q8.24 multiply: 32x32 -> 64-bit product, bits [55:24] kept.
// SIGMOID_ROUND_EN adds half an LSB before slicing (round half up); otherwise floor.
module q824_mul
    import sigmoid_pkg::*;
(
    input  logic signed [DWIDTH-1:0] a,
    input  logic signed [DWIDTH-1:0] b,
    output logic signed [DWIDTH-1:0] p
);

    localparam logic [2*DWIDTH-1:0] HALF = {{(2*DWIDTH-1){1'b0}}, 1'b1} << (FRAC - 1);

    logic signed [2*DWIDTH-1:0] prod;
    logic        [2*DWIDTH-1:0] prod_adj;
    logic                       unused_prod;

    always_comb begin
        prod = a * b;
`ifdef SIGMOID_ROUND_EN
        prod_adj = prod + HALF;
`else
        prod_adj = prod;
`endif
        p = prod_adj[FRAC+DWIDTH-1:FRAC];
    end

    assign unused_prod = ^{prod_adj[2*DWIDTH-1:FRAC+DWIDTH], prod_adj[FRAC-1:0], HALF[0]};

endmodule

// File: rtl/sigmoid_series_eval.sv
// Sequential sigmoid: segment select, coefficient capture, two-step Horner MAC, clamp/mirror.
// Optional macro SIGMOID_ROUND_EN selects round-half-up in the shared multiplier.
module sigmoid_series_eval
    import sigmoid_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic [2:0]        seg,
    input  logic [DWIDTH-1:0] coef_t1,
    input  logic [DWIDTH-1:0] coef_t2,
    input  logic [DWIDTH-1:0] coef_t3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data
);

    localparam int unsigned IW = DWIDTH - FRAC + 1;

    state_e                    state_q, state_d;
    logic                      neg_q, neg_d;
    logic        [DWIDTH-1:0]  mag_q, mag_d;
    logic        [2:0]         seg_q, seg_d;
    logic        [DWIDTH-1:0]  t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic        [DWIDTH-1:0]  d_q, d_d;
    logic signed [DWIDTH-1:0]  acc_q, acc_d;
    logic        [DWIDTH-1:0]  out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;

    logic        [DWIDTH:0]    x_ext, abs_x;
    logic        [DWIDTH-1:0]  base_ext, r;
    logic signed [DWIDTH-1:0]  mul_b, mul_p;

    // 33-bit magnitude so that the most negative operand stays representable.
    assign x_ext    = {in_data[DWIDTH-1], in_data};
    assign abs_x    = in_data[DWIDTH-1] ? (~x_ext + 1'b1) : x_ext;
    assign base_ext = DWIDTH'(seg_base(seg_q)) << FRAC;
    assign mul_b    = (state_q == StMac1) ? t3_q : acc_q;

    q824_mul u_mul (
        .a (d_q),
        .b (mul_b),
        .p (mul_p)
    );

    always_comb begin
        if (seg_q >= SEG_SAT) begin
            r = ONE;
        end else if (acc_q < 0) begin
            r = '0;
        end else if (acc_q > $signed(ONE)) begin
            r = ONE;
        end else begin
            r = acc_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        seg_d       = seg_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        t3_d        = t3_q;
        d_d         = d_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    neg_d   = in_data[DWIDTH-1];
                    mag_d   = abs_x[DWIDTH-1:0];
                    seg_d   = (abs_x[DWIDTH:FRAC] >= IW'(SEG_SAT)) ? SEG_SAT
                                                                   : abs_x[FRAC+2:FRAC];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                t1_d    = coef_t1;
                t2_d    = coef_t2;
                t3_d    = coef_t3;
                d_d     = mag_q - base_ext;
                state_d = StMac1;
            end
            StMac1: begin
                acc_d   = t2_q + mul_p;
                state_d = StMac2;
            end
            StMac2: begin
                acc_d   = t1_q + mul_p;
                state_d = StFix;
            end
            StFix: begin
                out_data_d  = neg_q ? (ONE - r) : r;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            seg_q       <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            t3_q        <= '0;
            d_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            seg_q       <= seg_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            t3_q        <= t3_d;
            d_q         <= d_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign seg       = seg_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sigmoid_series_eval.sv
// Directed bench for sigmoid_series_eval with a small per-segment coefficient table.
module tb_sigmoid_series_eval;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [2:0]  seg;
    logic [31:0] coef_t1, coef_t2, coef_t3;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int tests = 0;
    int fails = 0;

`ifdef SIGMOID_ROUND_EN
    localparam logic [31:0] EXP_S4 = 32'h00F2_4401;
    localparam logic [31:0] EXP_S5 = 32'h00F6_B403;
    localparam logic [31:0] EXP_N5 = 32'h0009_4BFD;
`else
    localparam logic [31:0] EXP_S4 = 32'h00F2_4400;
    localparam logic [31:0] EXP_S5 = 32'h00F6_B401;
    localparam logic [31:0] EXP_N5 = 32'h0009_4BFF;
`endif

    always #5 clk = ~clk;

    sigmoid_series_eval dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .seg       (seg),
        .coef_t1   (coef_t1),
        .coef_t2   (coef_t2),
        .coef_t3   (coef_t3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Seg 4/5 share a table entry; t3 is a small negative value so rounding matters.
    always_comb begin
        coef_t1 = 32'h0;
        coef_t2 = 32'h0;
        coef_t3 = 32'h0;
        case (seg)
            3'd0: begin coef_t1 = 32'h0080_0000; coef_t2 = 32'h0040_0000; end
            3'd1: begin coef_t1 = 32'h00BB_26A6; coef_t2 = 32'h0010_0000;
                        coef_t3 = 32'h0001_0000; end
            3'd2: coef_t1 = 32'hFF00_0000;
            3'd3: coef_t1 = 32'h0110_0000;
            3'd4, 3'd5: begin coef_t1 = 32'h00F0_0000; coef_t2 = 32'h0004_9000;
                              coef_t3 = 32'hFFFF_F001; end
            default: ;
        endcase
    end

    task automatic run_op(input logic [31:0] x, input logic [2:0] exp_seg,
                          input logic [31:0] exp_data, input string name);
        int lat;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (seg !== exp_seg) begin
            fails++;
            $display("FAIL %s seg: got %0d want %0d", name, seg, exp_seg);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (lat != 4) begin
            fails++;
            $display("FAIL %s latency: got %0d want 4", name, lat);
        end
        tests++;
        if (out_data !== exp_data) begin
            fails++;
            $display("FAIL %s out_data: got %h want %h", name, out_data, exp_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s after transfer: got out_valid=%b in_ready=%b want 0/1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || seg !== 3'd0) begin
            fails++;
            $display("FAIL reset state: got rdy=%b vld=%b data=%h seg=%0d want 1/0/0/0",
                     in_ready, out_valid, out_data, seg);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero();
        run_op(32'h0000_0000, 3'd0, 32'h0080_0000, "zero");
        run_op(32'h0080_0000, 3'd0, 32'h00A0_0000, "seg0_half");
    endtask

    task automatic test_unit();
        run_op(32'h0100_0000, 3'd1, 32'h00BB_26A6, "pos_one");
        run_op(32'hFF00_0000, 3'd1, 32'h0044_D95A, "neg_one");
    endtask

    task automatic test_saturation();
        run_op(32'h0700_0000, 3'd6, 32'h0100_0000, "sat_pos");
        run_op(32'hF900_0000, 3'd6, 32'h0000_0000, "sat_neg");
        run_op(32'h8000_0000, 3'd6, 32'h0000_0000, "most_neg");
    endtask

    task automatic test_clamp();
        run_op(32'h0200_0000, 3'd2, 32'h0000_0000, "clamp_low");
        run_op(32'hFE00_0000, 3'd2, 32'h0100_0000, "clamp_low_neg");
        run_op(32'h0300_0000, 3'd3, 32'h0100_0000, "clamp_high");
    endtask

    task automatic test_segment_base();
        run_op(32'h0480_0000, 3'd4, EXP_S4, "seg4_horner");
        run_op(32'h0580_0000, 3'd5, EXP_S5, "seg5_horner");
    endtask

    task automatic test_back_pressure();
        int lat;
        logic [31:0] held;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0100_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        held = out_data;
        tests++;
        if (held !== 32'h00BB_26A6) begin
            fails++;
            $display("FAIL bp result: got %h want 00bb26a6", held);
        end
        in_valid = 1'b1;
        in_data  = 32'h0700_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'h00BB_26A6 || in_ready !== 1'b0 ||
                seg !== 3'd1) begin
                fails++;
                $display("FAIL bp hold %0d: got vld=%b data=%h rdy=%b seg=%0d want 1/00bb26a6/0/1",
                         i, out_valid, out_data, in_ready, seg);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || seg !== 3'd1) begin
            fails++;
            $display("FAIL bp transfer: got vld=%b rdy=%b seg=%0d want 0/1/1",
                     out_valid, in_ready, seg);
        end
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp single transfer: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0580_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || seg !== 3'd0) begin
            fails++;
            $display("FAIL mid-op reset: got vld=%b rdy=%b data=%h seg=%0d want 0/1/0/0",
                     out_valid, in_ready, out_data, seg);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'hFA80_0000, 3'd5, EXP_N5, "after_reset_neg5");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_unit();
        test_saturation();
        test_clamp();
        test_segment_base();
        test_back_pressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sigmoid_series_eval.md
Name: sigmoid_series_eval

Overview:
- Sequential sigmoid evaluator. It is the consumer side of the per-segment Maclaurin coefficient lookup tables.
- Accepts one signed Q8.24 operand and computes the segment index, which it drives onto the coefficient LUT select lines.
- Captures the term-1/2/3 coefficients and evaluates y = t1 + d*(t2 + d*t3) by Horner's method with one shared multiplier.
- Returns sigmoid(x) in Q8.24 under a valid/ready handshake. Sits between the neuron accumulator and the next layer's input buffer.

Parameters:
- DWIDTH, 32, data/coefficient width; signed Q8.24 fixed point.
- FRAC, 24, fractional bits.
- SEG_SAT, 6, segment index at and above which the output saturates.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand
- in_data  in  DWIDTH  signed Q8.24 operand x
- seg  out  3  segment select to the coefficient LUTs
- coef_t1  in  DWIDTH  term-1 coefficient for seg (combinational LUT return)
- coef_t2  in  DWIDTH  term-2 coefficient for seg
- coef_t3  in  DWIDTH  term-3 coefficient for seg
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  DWIDTH  sigmoid(x), Q8.24, range [0, 0x01000000]

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, seg=0. FSM goes to IDLE, all datapath registers are cleared. Reset mid-operation aborts the current operand with no output.
- FSM states: IDLE, LOOKUP, MAC1, MAC2, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register neg = x[31] and mag = |x|, computed 33 bits wide so that x=0x80000000 does not overflow.
  - Register seg = min(mag>>24, 6). Go to LOOKUP.
- LOOKUP: seg is stable. Register t1/t2/t3 from coef ports. Register d = mag - (base<<24), where base = 4 for seg 4 or 5, base = seg otherwise. Go to MAC1.
- MAC1: acc = t2 + mul(d, t3). Go to MAC2.
- MAC2: acc = t1 + mul(d, acc). Go to FIX.
- FIX:
  - If seg >= SEG_SAT, r = 0x01000000.
  - Otherwise r = acc clamped to [0, 0x01000000].
  - out_data = neg ? 0x01000000 - r : r.
  - Set out_valid=1. Go to DONE.
- DONE: hold out_data and out_valid until out_ready=1. On that cycle: out_valid=0, in_ready=1, go to IDLE.
- in_ready is 0 in every state except IDLE. There is no overlap between operands.
- Latency: accept edge to out_valid high = 4 cycles. Minimum initiation interval = 6 cycles when out_ready is held high.
- mul(a, b): signed 32x32 -> 64-bit product, result = product[55:24], arithmetic truncation toward -inf. No intermediate saturation; only the final clamp applies.
- x = +0 and -0 are identical. A zero-magnitude negative gives 0x01000000 - t1 at seg 0.
- out_ready held high in DONE yields exactly one transfer.

Optional Feature:
- Macro: SIGMOID_ROUND_EN.
- Defined: mul adds 1<<23 to the 64-bit product before extracting [55:24] (round half up).
- Undefined: pure truncation as above.
- Latency and handshake are unchanged either way.

Decomposition:
- Shared package sigmoid_pkg holds:
  - DWIDTH and FRAC
  - the Q8.24 ONE constant, 0x01000000
  - SEG_SAT
  - the FSM state enum
  - the segment-base function
- Natural sub-module: q824_mul (signed multiply, slice and optional round). It is instantiated once and shared between MAC1 and MAC2.
- Coefficient LUTs stay outside the block.

Test Plan:
- x=0x00000000, bench LUT seg0 t1=0x00800000 -> seg=0, out_data=0x00800000, out_valid exactly 4 cycles after accept.
- x=0x01000000, bench seg1 t1=0x00BB26A6 (d=0) -> seg=1, out_data=0x00BB26A6. x=0xFF000000 -> out_data=0x0044D95A.
- x=0x07000000 -> seg=6, out_data=0x01000000. x=0xF9000000 -> 0x00000000. x=0x80000000 -> seg=6, out_data=0x00000000.
- x=0x05800000 -> seg=5, d=0x01800000 (base 4); out_data matches a Horner reference model bit-exactly, both with and without SIGMOID_ROUND_EN.
- Back-pressure: out_ready low for 3 cycles in DONE -> out_data/out_valid stable, in_ready=0, new in_valid ignored. Transfer on first out_ready=1 cycle; in_ready=1 on that cycle.
- Assert rst during MAC1 -> out_valid=0, in_ready=1, out_data=0 immediately. Next operand completes normally.
